// File: rtl/sequence_transmitter_1101.sv
// Purpose: frames a latched payload behind a 1101 preamble on a serial line, then handshakes done/ack with the far end.
// Latency: first preamble bit on data one cycle after the accepting edge; ack one cycle after done is sampled in WAIT_DONE.
// Backpressure: start is honoured only while ready=1; requests while busy are dropped, never queued.
module sequence_transmitter_1101 #(
    parameter int PAYLOAD_W    = 4,
    parameter int IDLE_GAP     = 2,
    parameter int DONE_TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PAYLOAD_W-1:0] payload,
    output logic                 ready,
    output logic                 data,
    output logic                 sending,
    input  logic                 done,
    output logic                 ack,
    output logic                 error
);

    // Frame = 4 preamble bits followed by the payload, MSB first.
    localparam int FRAME_W   = 4 + PAYLOAD_W;
    localparam int BIT_CNT_W = $clog2(FRAME_W + 1);
    localparam int TMO_CNT_W = $clog2(DONE_TIMEOUT + 1);
    localparam int GAP_CNT_W = $clog2(IDLE_GAP + 1);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_W);
    localparam logic [BIT_CNT_W-1:0] PRE_BITS = BIT_CNT_W'(4);
    localparam logic [BIT_CNT_W-1:0] BIT_ONE  = BIT_CNT_W'(1);
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [TMO_CNT_W-1:0] TMO_ONE  = TMO_CNT_W'(1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(IDLE_GAP - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_ONE  = GAP_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_PAY,
        S_WAIT_DONE,
        S_ACK,
        S_GAP
    } state_t;

    state_t               state;
    // Bits still to be sent, left-aligned; the leading preamble bit goes
    // straight onto data at accept, so only the remaining bits live here.
    logic [FRAME_W-1:0]   frame_sh;
    // Number of frame bits already placed on data.
    logic [BIT_CNT_W-1:0] bit_cnt;
    // Cycles spent in WAIT_DONE with done low.
    logic [TMO_CNT_W-1:0] tmo_cnt;
    // Cycles spent in GAP.
    logic [GAP_CNT_W-1:0] gap_cnt;

    // Single FSM with every output registered; reset forces the idle picture immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            ready    <= 1'b1;
            data     <= 1'b0;
            sending  <= 1'b0;
            ack      <= 1'b0;
            error    <= 1'b0;
            frame_sh <= '0;
            bit_cnt  <= '0;
            tmo_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_PRE;
                        ready    <= 1'b0;
                        sending  <= 1'b1;
                        error    <= 1'b0;
                        data     <= 1'b1;
                        frame_sh <= {3'b101, payload, 1'b0};
                        bit_cnt  <= BIT_ONE;
                    end
                end

                S_PRE, S_PAY: begin
                    if (bit_cnt == LAST_BIT) begin
                        // Last bit has had its cycle; line returns low while we wait.
                        state   <= S_WAIT_DONE;
                        data    <= 1'b0;
                        sending <= 1'b0;
                        tmo_cnt <= '0;
                    end else begin
                        data     <= frame_sh[FRAME_W-1];
                        frame_sh <= {frame_sh[FRAME_W-2:0], 1'b0};
                        bit_cnt  <= bit_cnt + BIT_ONE;
                        // Bit index bit_cnt is about to be shown; index 4 and up is payload.
                        state    <= (bit_cnt >= PRE_BITS) ? S_PAY : S_PRE;
                    end
                end

                S_WAIT_DONE: begin
                    // done is checked first so it wins a tie with the timeout.
                    if (done) begin
                        state <= S_ACK;
                        ack   <= 1'b1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state   <= S_GAP;
                        error   <= 1'b1;
                        gap_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                    end
                end

                S_ACK: begin
                    state   <= S_GAP;
                    ack     <= 1'b0;
                    gap_cnt <= '0;
                end

                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_ONE;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    ready   <= 1'b1;
                    data    <= 1'b0;
                    sending <= 1'b0;
                    ack     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_transmitter_1101.sv
// Purpose: checks two transmitter instances (4-bit and 1-bit payload) cycle by cycle against a timeline model.
// Latency: stimulus applied 1 time unit after each rising edge, outputs sampled on the falling edge.
// Backpressure: the model decides when start is accepted from its own view of ready.
module tb_sequence_transmitter_1101;

    localparam int NCYC = 1200;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       done = 1'b0;
    logic [3:0] payload_a = '0;
    logic [0:0] payload_b = '0;

    logic ready_a, data_a, sending_a, ack_a, error_a;
    logic ready_b, data_b, sending_b, ack_b, error_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus per cycle, applied during that cycle and sampled at its closing edge.
    bit         s_rst   [NCYC];
    bit         s_start [NCYC];
    bit         s_done  [NCYC];
    logic [3:0] s_pay   [NCYC];

    // Expected outputs per instance (0 = 4-bit payload, 1 = 1-bit payload).
    bit e_rdy [2][NCYC];
    bit e_dat [2][NCYC];
    bit e_snd [2][NCYC];
    bit e_ack [2][NCYC];
    bit e_err [2][NCYC];

    always #5 clk = ~clk;

    sequence_transmitter_1101 #(
        .PAYLOAD_W(4), .IDLE_GAP(2), .DONE_TIMEOUT(20)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start), .payload(payload_a),
        .ready(ready_a), .data(data_a), .sending(sending_a),
        .done(done), .ack(ack_a), .error(error_a)
    );

    sequence_transmitter_1101 #(
        .PAYLOAD_W(1), .IDLE_GAP(3), .DONE_TIMEOUT(15)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start), .payload(payload_b),
        .ready(ready_b), .data(data_b), .sending(sending_b),
        .done(done), .ack(ack_b), .error(error_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Bit i of a frame: 1101 preamble, then payload MSB first.
    function automatic bit frame_bit(input logic [3:0] lp, input int w, input int i);
        if (i < 4) return (i != 2);
        return lp[w - 1 - (i - 4)];
    endfunction

    // Timeline model: on accept, lay out the whole frame (bit cycles, first done
    // within the window, ack/timeout, gap length) as absolute cycle numbers.
    task automatic build_expect(input int id, input int w, input int g, input int t);
        int         n;
        bit         busy;
        bit         err;
        int         t_acc, t_ack, t_err, t_idle, ws, off;
        logic [3:0] lp;
        n = 4 + w; busy = 0; err = 0;
        t_acc = 0; t_ack = -1; t_err = -1; t_idle = 0; lp = '0;
        for (int k = 0; k < NCYC; k++) begin
            if (!s_rst[k]) begin
                busy = 0; err = 0;
                e_rdy[id][k] = 1; e_dat[id][k] = 0; e_snd[id][k] = 0;
                e_ack[id][k] = 0; e_err[id][k] = 0;
            end else begin
                if (busy && k >= t_idle) begin
                    busy = 0;
                    err  = (t_ack < 0);
                end
                if (!busy) begin
                    e_rdy[id][k] = 1; e_dat[id][k] = 0; e_snd[id][k] = 0;
                    e_ack[id][k] = 0; e_err[id][k] = err;
                    if (s_start[k]) begin
                        busy = 1; t_acc = k; lp = s_pay[k]; err = 0;
                        ws = k + n + 1;
                        t_ack = -1;
                        for (int c = ws; c < ws + t && c < NCYC; c++)
                            if (s_done[c] && t_ack < 0) t_ack = c + 1;
                        if (t_ack >= 0) begin
                            t_err  = -1;
                            t_idle = t_ack + 1 + g;
                        end else begin
                            t_err  = ws + t;
                            t_idle = t_err + g;
                        end
                    end
                end else begin
                    off = k - t_acc;
                    e_rdy[id][k] = 0;
                    e_snd[id][k] = (off >= 1 && off <= n);
                    e_dat[id][k] = e_snd[id][k] ? frame_bit(lp, w, off - 1) : 1'b0;
                    e_ack[id][k] = (k == t_ack);
                    e_err[id][k] = (t_err >= 0 && k >= t_err);
                end
            end
        end
    endtask

    initial begin
        logic [7:0] cap_a;
        logic [4:0] cap_b;
        cap_a = '0;
        cap_b = '0;

        // Directed opening, then random traffic.
        for (int k = 0; k < NCYC; k++) begin
            s_pay[k] = 4'($urandom_range(0, 15));
            if (k < 110) begin
                s_rst[k]   = !(k < 3 || k == 81);
                s_start[k] = (k == 3 || k == 5 || k == 22 || k == 60 || k == 75 || k == 83);
                s_done[k]  = (k == 16 || k == 17) || (k >= 60 && k <= 90) || (k == 100 || k == 101);
            end else begin
                s_rst[k]   = ($urandom_range(0, 199) != 0);
                s_start[k] = ($urandom_range(0, 3) == 0);
                s_done[k]  = ($urandom_range(0, 24) == 0);
            end
        end
        s_pay[3]  = 4'b1010;   // first frame
        s_pay[5]  = 4'b1111;   // start while busy, must be ignored
        s_pay[60] = 4'b0001;   // 1-bit instance sends payload 1

        build_expect(0, 4, 2, 20);
        build_expect(1, 1, 3, 15);

        for (int k = 0; k < NCYC; k++) begin
            @(posedge clk);
            #1;
            reset     = s_rst[k];
            start     = s_start[k];
            done      = s_done[k];
            payload_a = s_pay[k];
            payload_b = s_pay[k][0];
            @(negedge clk);
            chk($sformatf("a.ready@%0d", k),   32'(ready_a),   32'(e_rdy[0][k]));
            chk($sformatf("a.data@%0d", k),    32'(data_a),    32'(e_dat[0][k]));
            chk($sformatf("a.sending@%0d", k), 32'(sending_a), 32'(e_snd[0][k]));
            chk($sformatf("a.ack@%0d", k),     32'(ack_a),     32'(e_ack[0][k]));
            chk($sformatf("a.error@%0d", k),   32'(error_a),   32'(e_err[0][k]));
            chk($sformatf("b.ready@%0d", k),   32'(ready_b),   32'(e_rdy[1][k]));
            chk($sformatf("b.data@%0d", k),    32'(data_b),    32'(e_dat[1][k]));
            chk($sformatf("b.sending@%0d", k), 32'(sending_b), 32'(e_snd[1][k]));
            chk($sformatf("b.ack@%0d", k),     32'(ack_b),     32'(e_ack[1][k]));
            chk($sformatf("b.error@%0d", k),   32'(error_b),   32'(e_err[1][k]));
            if (k >= 4 && k <= 11)  cap_a = {cap_a[6:0], data_a};
            if (k >= 61 && k <= 65) cap_b = {cap_b[3:0], data_b};
        end

        chk("a.serial_1010", 32'(cap_a), 32'(8'b1101_1010));
        chk("b.serial_w1",   32'(cap_b), 32'(5'b1101_1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sequence_transmitter_1101.md
SEQUENCE_TRANSMITTER_1101 -- requirements
Module: sequence_transmitter_1101

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 4: payload bits sent after the preamble, range 1..16.
REQ-002 SHALL have parameter IDLE_GAP, default 2: forced data=0 cycles after each frame before ready re-asserts, range 1..255.
REQ-003 SHALL have parameter DONE_TIMEOUT, default 1000: maximum cycles waited for done, range 1..65535.
REQ-004 SHALL have port clk  input  1  -- the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  -- asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port start  input  1  -- frame request; accepted only when ready=1.
REQ-007 SHALL have port payload  input  PAYLOAD_W  -- frame payload, latched on accept.
REQ-008 SHALL have port ready  output  1  -- idle and able to accept start.
REQ-009 SHALL have port data  output  1  -- registered serial line to the 1101 detector.
REQ-010 SHALL have port sending  output  1  -- high while the preamble or payload is on data.
REQ-011 SHALL have port done  input  1  -- completion level from the far-end receiver.
REQ-012 SHALL have port ack  output  1  -- one-cycle acknowledge of done.
REQ-013 SHALL have port error  output  1  -- sticky done-timeout flag.

Function
REQ-014 SHALL implement states IDLE, PRE, PAY, WAIT_DONE, ACK and GAP.
REQ-015 IDLE: ready=1, data=0; on a clk edge with start=1, latch payload, clear error, go to PRE.
REQ-016 PRE: data SHALL be 1,1,0,1 in the 4 cycles following accept; first bit valid in the cycle after the accepting edge.
REQ-017 PAY: data SHALL carry the latched payload MSB-first, one bit per cycle, for PAYLOAD_W cycles immediately after the preamble, with no gap.
REQ-018 sending SHALL be 1 exactly during the 4+PAYLOAD_W bit cycles, else 0; ready SHALL be 0 in all states except IDLE.
REQ-019 Entering WAIT_DONE, data SHALL be 0; a timeout counter SHALL start at 0.
REQ-020 WAIT_DONE, done=1 sampled: go to ACK, in which ack=1 for exactly one cycle; then go to GAP.
REQ-021 WAIT_DONE, done=0 for DONE_TIMEOUT consecutive cycles: set error=1, go to GAP, with no ack.
REQ-022 If done=1 and the timeout expire on the same edge, done SHALL win: ack is issued, error stays 0.
REQ-023 GAP: data=0 for IDLE_GAP cycles, then IDLE.
REQ-024 done SHALL be ignored outside WAIT_DONE, including done already high during PRE/PAY; it is sampled only from the first WAIT_DONE cycle.
REQ-025 start SHALL be ignored while ready=0; no queuing. Payload changes after accept SHALL NOT affect the frame.
REQ-026 Payload bits forming 1101 SHALL be sent unmodified; no bit stuffing.
REQ-027 error SHALL hold until the next accepted start, or until reset.
REQ-028 Counters SHALL be sized for their parameter maxima and SHALL NOT wrap within a state.

Reset
REQ-029 reset=0 SHALL, asynchronously and without waiting for a clock edge, force IDLE: data=0, sending=0, ack=0, error=0, ready=1, counters=0.
REQ-030 Reset mid-frame SHALL abort the frame; data SHALL drop to 0 in the same instant; the state after release SHALL be IDLE.
REQ-031 The first start SHALL be accepted on the first rising edge after reset=1.

Verification
REQ-032 Defaults, payload=4'b1010, start pulse, done raised 5 cycles after the last bit -> data=1,1,0,1,1,0,1,0; sending high 8 cycles; ack 1 cycle; ready returns 1 cycle+2 GAP cycles after ack.
REQ-033 start asserted again at PRE cycle 2 with payload=4'b1111 -> ignored; frame carries the original payload; no second frame.
REQ-034 done held 0 with DONE_TIMEOUT=20 -> error=1 after 20 WAIT_DONE cycles; ack never asserted; the next start clears error.
REQ-035 reset=0 during payload bit 2 -> data=0 and ready=1 immediately; the next start produces a complete, correct frame.
REQ-036 done=1 throughout the frame -> ack occurs in the cycle after the first WAIT_DONE cycle, not earlier.
REQ-037 PAYLOAD_W=1, payload=1 -> data=1,1,0,1,1; then WAIT_DONE.
